// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch -- instruction fetch front end with a small prefetch queue.
//
// Keeps one synchronous ROM read in flight and buffers returned instructions,
// together with the address each was fetched from, in a DEPTH-entry FIFO.
// Fetching is throttled so that in-flight reads plus queued entries never
// exceed DEPTH, which means a returning read always has a free slot.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high; wins over jump, push, pop, issue
//   pc_in        current program counter from the pc block
//   pc_incr      request the pc block to advance on the next edge
//   rom_addr     ROM address (combinationally equal to pc_in)
//   rom_data     ROM read data, valid one cycle after the address
//   jump         taken-branch flush; pc block loads its target on this edge
//   instr        head instruction (0 when the queue is empty)
//   instr_pc     address of the head instruction (0 when empty)
//   instr_valid  queue holds at least one instruction
//   instr_ready  downstream accepts the head this cycle
// -----------------------------------------------------------------------------
module fetch #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_in,
  output logic        pc_incr,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        jump,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  logic             req_valid_q, req_valid_d;
  logic [15:0]      req_pc_q,    req_pc_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [PTR_W-1:0] head_q,      head_d;
  logic [PTR_W-1:0] tail_q,      tail_d;

  logic [15:0] instr_mem_q [DEPTH];
  logic [15:0] instr_mem_d [DEPTH];
  logic [15:0] pc_mem_q    [DEPTH];
  logic [15:0] pc_mem_d    [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           push;
  logic           pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign rom_addr = pc_in;

  // Count the in-flight read as occupied so its return can never find the
  // queue full.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, req_valid_q};
  assign pc_incr   = !reset && !jump && (occupancy < DEPTH_EXT);

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? instr_mem_q[head_q] : 16'h0000;
  assign instr_pc    = instr_valid ? pc_mem_q[head_q]    : 16'h0000;

  // A jump discards the returning read and leaves the head in place.
  assign push = req_valid_q && !jump;
  assign pop  = instr_valid && instr_ready && !jump;

  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;

    if (push) begin
      instr_mem_d[tail_q] = rom_data;
      pc_mem_d[tail_q]    = req_pc_q;
      tail_d              = next_ptr(tail_q);
    end
    if (pop) begin
      head_d = next_ptr(head_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (jump) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_comb begin
    req_valid_d = pc_incr;
    req_pc_d    = pc_incr ? pc_in : req_pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      req_pc_q    <= 16'h0000;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch -- directed vector table plus a random-ready streaming run for fetch.
// The bench models the pc block (advance on pc_incr, load on jump, clear on
// reset) and a synchronous ROM with ROM[a] = a ^ 16'hA5A5.
// -----------------------------------------------------------------------------
module tb_fetch;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_in;
  logic        pc_incr;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        jump;
  logic [15:0] target;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks   = 0;
  int failures = 0;

  fetch #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_incr     (pc_incr),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .jump        (jump),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset)        pc_in <= 16'h0000;
    else if (jump)    pc_in <= target;
    else if (pc_incr) pc_in <= pc_in + 16'h0001;
  end

  always @(posedge clk) rom_data <= rom_addr ^ 16'hA5A5;

  typedef struct {
    logic        reset;
    logic        jump;
    logic [15:0] target;
    logic        ready;
    logic        exp_incr;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic j, input logic [15:0] t, input logic rd,
                     input logic ei, input logic ev, input logic [15:0] ep, input logic [15:0] ein);
    vec_t v;
    v.reset = r; v.jump = j; v.target = t; v.ready = rd;
    v.exp_incr = ei; v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ein;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    int exp_next;
    int accepted;
    logic        prev_hold;
    logic [15:0] prev_pc, prev_instr;

    //   rst jmp target    rdy incr vld pc        instr
    add(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000); // 0 held in reset
    add(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000); // 1 release, issue 0
    add(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000); // 2 issue 1, push 0
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0000, 16'hA5A5); // 3 first valid
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0001, 16'hA5A4);
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0002, 16'hA5A7);
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0003, 16'hA5A6);
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0004, 16'hA5A1);
    add(0, 1, 16'h0100, 1, 0, 1, 16'h0005, 16'hA5A0); // 8 jump, head 5 not taken
    add(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000); // 9 queue empty
    add(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000);
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0100, 16'hA4A5); // 11 target valid
    add(0, 0, 16'h0000, 0, 1, 1, 16'h0101, 16'hA4A4); // 12 stall begins
    add(0, 0, 16'h0000, 0, 0, 1, 16'h0101, 16'hA4A4); // 13 queue full
    add(0, 0, 16'h0000, 0, 0, 1, 16'h0101, 16'hA4A4);
    add(0, 0, 16'h0000, 1, 0, 1, 16'h0101, 16'hA4A4); // 15 drain resumes
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0102, 16'hA4A7);
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0103, 16'hA4A6);
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0104, 16'hA4A1);
    add(0, 1, 16'h0200, 1, 0, 1, 16'h0105, 16'hA4A0); // 19 jump x3
    add(0, 1, 16'h0200, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 1, 16'h0200, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000); // 22 still empty
    add(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000);
    add(0, 0, 16'h0000, 0, 1, 1, 16'h0200, 16'hA7A5); // 24 hold, fill
    add(1, 0, 16'h0000, 1, 0, 1, 16'h0200, 16'hA7A5); // 25 reset with 2 queued + 1 in flight
    add(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000);
    add(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000);
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0000, 16'hA5A5); // 28 first valid is pc 0

    reset = 1'b1; jump = 1'b0; target = 16'h0000; instr_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset       = vq[i].reset;
      jump        = vq[i].jump;
      target      = vq[i].target;
      instr_ready = vq[i].ready;
      #1;
      check("pc_incr",     i, {15'b0, pc_incr},     {15'b0, vq[i].exp_incr});
      check("instr_valid", i, {15'b0, instr_valid}, {15'b0, vq[i].exp_valid});
      check("instr_pc",    i, instr_pc,             vq[i].exp_pc);
      check("instr",       i, instr,                vq[i].exp_instr);
    end

    // Random ready streaming: accepted addresses must be consecutive from 0.
    @(negedge clk);
    reset = 1'b1; jump = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_next  = 0;
    accepted  = 0;
    prev_hold = 1'b0;
    prev_pc   = 16'h0000;
    prev_instr = 16'h0000;
    for (int c = 0; c < 1000; c++) begin
      if (c != 0) @(negedge clk);
      instr_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (int'(dut.count_q) > DEPTH) begin
        failures++;
        $display("FAIL count_bound cycle=%0d actual=%0d required<=%0d", c, dut.count_q, DEPTH);
      end
      if (prev_hold) begin
        check("hold_valid", c, {15'b0, instr_valid}, 16'h0001);
        check("hold_pc",    c, instr_pc, prev_pc);
        check("hold_instr", c, instr,    prev_instr);
      end
      if (instr_valid && instr_ready) begin
        check("stream_pc",    c, instr_pc, 16'(exp_next));
        check("stream_instr", c, instr,    16'(exp_next) ^ 16'hA5A5);
        exp_next++;
        accepted++;
      end
      prev_hold  = instr_valid && !instr_ready;
      prev_pc    = instr_pc;
      prev_instr = instr;
    end
    checks++;
    if (accepted < 300) begin
      failures++;
      $display("FAIL stream_throughput actual=%0d required>=300", accepted);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter DEPTH, default 3: instruction queue entries; legal range 2..8.
REQ-002 The port list SHALL be one clock; reset is synchronous and active-high (clock port clk, reset port reset).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 pc_in  input  16  current program-counter value from upstream pc block.
REQ-006 pc_incr  output  1  advance request to pc block (pc increments on next edge).
REQ-007 rom_addr  output  16  instruction ROM address; combinationally equal to pc_in.
REQ-008 rom_data  input  16  synchronous ROM data; ROM[rom_addr] valid exactly one cycle after address.
REQ-009 jump  input  1  taken-branch flush from execute; pc block loads the target on the same edge.
REQ-010 instr  output  16  instruction at queue head.
REQ-011 instr_pc  output  16  address the head instruction was fetched from.
REQ-012 instr_valid  output  1  queue head holds a valid instruction.
REQ-013 instr_ready  input  1  downstream accepts head when instr_valid=1.

Function
REQ-014 State: req_valid/req_pc (one in-flight ROM read) plus a DEPTH-entry FIFO of {instr, pc} with count 0..DEPTH.
REQ-015 pc_incr SHALL be combinational: 1 iff reset=0, jump=0, and count + req_valid < DEPTH.
REQ-016 Issue edge (pc_incr=1): req_valid<=1, req_pc<=pc_in; otherwise req_valid<=0.
REQ-017 Return edge (req_valid=1, jump=0): push {rom_data, req_pc} into FIFO tail.
REQ-018 Pop: edge where instr_valid=1, instr_ready=1 and jump=0 removes head; push and pop in one edge leave count unchanged.
REQ-019 instr_valid = (count != 0); instr and instr_pc SHALL be 0 whenever instr_valid=0.
REQ-020 Issue rule guarantees count never exceeds DEPTH; push while full SHALL never occur (assertable).
REQ-021 instr, instr_pc, instr_valid SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-022 Throughput: with instr_ready held 1 and no jumps, one instruction accepted per cycle in steady state (DEPTH>=3).
REQ-023 Latency: address issued on edge N appears at head, instr_valid=1, after edge N+1 (two cycles from reset release to first valid).
REQ-024 jump=1: on that edge count<=0, req_valid<=0, in-flight rom_data discarded, head not popped even if instr_ready=1; pc_incr=0 that cycle.
REQ-025 Cycle after jump: pc_in is the target; issue resumes under REQ-015; first target instruction valid two cycles after jump edge.
REQ-026 Consecutive jump cycles: each re-flushes; no instruction becomes valid until jump deasserts.
REQ-027 rom_addr and instr_pc are 16-bit unsigned; address 16'hFFFF wraps to 0 via the pc block with no special handling here.

Reset
REQ-028 reset=1 on an edge: count<=0, req_valid<=0, req_pc<=0, FIFO contents irrelevant; pc_incr=0 while reset=1.
REQ-029 reset has priority over jump, push, pop and issue.
REQ-030 After reset: instr_valid=0, instr=0, instr_pc=0, pc_incr=1 on first cycle with reset=0.
REQ-031 Reset mid-stream discards queued and in-flight instructions; no stale entry appears afterwards.

Verification (ROM model: ROM[a] = a ^ 16'hA5A5, bench pc block increments on pc_incr, loads on jump)
REQ-032 Reset then ready=1 for 6 cycles -> instr_valid rises 2 cycles after release; instr_pc sequence 0,1,2,3 with instr 16'hA5A5,16'hA5A4,16'hA5A7,16'hA5A6.
REQ-033 ready=0 from reset release -> count reaches 3 (instr_pc 0,1,2 queued), pc_incr=0 with pc_in=3; ready=1 -> instr_pc 0,1,2,3,... gapless, one per cycle.
REQ-034 jump=1 with target 16'h0100 while head instr_pc=5, ready=1 -> instr 5 not accepted, queue empty next cycle, next valid is instr_pc=16'h0100, instr=16'hA4A5 two cycles later.
REQ-035 jump asserted 3 consecutive cycles -> instr_valid=0 throughout and one cycle after; pc_incr=0 during all three.
REQ-036 reset=1 for one cycle with 2 queued and 1 in flight -> instr_valid=0 next cycle; first valid after release is instr_pc=0.
REQ-037 Random ready toggling over 1000 cycles, no jumps -> accepted instr_pc strictly consecutive from 0; count never exceeds DEPTH.
